// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        START_BIT       = 1'b0;
  localparam logic        STOP_BIT        = 1'b1;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises ps2_clk/ps2_data, deglitches the clock and emits a one-cycle
// strobe on each filtered falling edge together with the synchronised data bit.
module ps2_clk_filter #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sample,
  output logic sdata
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [CW-1:0]          cnt;
  logic                   fclk;
  logic                   sclk;

  assign sclk  = clk_sync[SYNC_STAGES-1];
  assign sdata = data_sync[SYNC_STAGES-1];

  // cnt tracks how long sclk has disagreed with fclk; any agreement restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      cnt       <= '0;
      fclk      <= 1'b1;
      sample    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      sample    <= 1'b0;
      if (sclk == fclk) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        fclk   <= sclk;
        cnt    <= '0;
        sample <= ~sclk;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame FSM with timeout, sticky error flags and
// a first-word-fall-through byte FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [7:0]                  data,
  output logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW    = $clog2(FRAME_DATA_BITS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_DATA_BITS - 1);

  logic sample, sdata;

  ps2_clk_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .sample  (sample),
    .sdata   (sdata)
  );

  ps2_state_t                 state, state_n;
  logic [BW-1:0]              bit_cnt, bit_cnt_n;
  logic [FRAME_DATA_BITS-1:0] shreg, shreg_n;
  logic                       par, par_n;
  logic [TW-1:0]              tmo, tmo_n;
  logic                       push, fe_ev, pe_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tmo     <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    tmo_n     = '0;
    push      = 1'b0;
    fe_ev     = 1'b0;
    pe_ev     = 1'b0;
    if (state != IDLE && !sample) begin
      if (tmo == TMO_LAST) begin
        state_n = IDLE;
        fe_ev   = 1'b1;
      end else begin
        tmo_n = tmo + TW'(1);
      end
    end
    if (sample) begin
      unique case (state)
        IDLE: if (sdata == START_BIT) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          shreg_n[bit_cnt] = sdata;
          if (bit_cnt == BIT_LAST) state_n = PARITY;
          else bit_cnt_n = bit_cnt + BW'(1);
        end
        PARITY: begin
          par_n   = sdata;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (sdata != STOP_BIT)     fe_ev = 1'b1;
          else if (!(^{shreg, par})) pe_ev = 1'b1;
          else                       push  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, full, wr, ovf_ev;

  assign ready  = (level != '0);
  assign full   = (level == LW'(FIFO_DEPTH));
  assign pop    = rd_en & ready;
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign wr     = push & (~full | pop);
  assign ovf_ev = push & full & ~pop;
  assign data   = ready ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (wr && !pop)      level <= level + LW'(1);
      else if (!wr && pop) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ovf_ev)       overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (pe_ev)        parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (fe_ev)        frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized frame stimulus for ps2_rx_fifo, checked against a
// queue-based model of received bytes and sticky flags.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_en, clr_err;
  logic [7:0] data;
  logic       ready;
  logic [3:0] level;
  logic       overflow, parity_err, frame_err;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(3),
    .FILTER_LEN (4),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .data      (data),
    .ready     (ready),
    .level     (level),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  int   n_asserts = 0;
  int   n_fail    = 0;
  int   lat_s     = 7;
  logic [7:0] q[$];
  bit   m_ovf, m_pe, m_fe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, "/ready"}, ready, q.size() != 0);
    chk({tag, "/level"}, level, q.size());
    chk({tag, "/data"}, data, head);
    chk({tag, "/overflow"}, overflow, m_ovf);
    chk({tag, "/parity_err"}, parity_err, m_pe);
    chk({tag, "/frame_err"}, frame_err, m_fe);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic p, input logic stp);
    if (!stp) m_fe = 1'b1;
    else if (!(^{b, p})) m_pe = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back(b);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic do_clear();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    m_ovf = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
  endtask

  // strobe: 0 none, 1 rd_en in the stop-sample cycle, 2 clr_err there, 3 measure latency
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stp,
                            input int glitch_bit, input int strobe, input int nbits);
    logic [10:0] bits;
    bit found;
    bits = {stp, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        cyc(5); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(HALF - 7);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10 && strobe == 3) begin
        found = 1'b0;
        for (int n = 1; n <= HALF - 3; n++) begin
          cyc(1);
          if (dut.sample === 1'b1) begin lat_s = n; found = 1'b1; break; end
        end
        chk("stop_sample_seen", found, 1'b1);
        chk("pre_push/ready", ready, 1'b0);
        chk("pre_push/level", level, 4'd0);
        cyc(1);
        chk("push_lat/ready", ready, 1'b1);
        chk("push_lat/data", data, 8'h1C);
        chk("push_lat/level", level, 4'd1);
        cyc(found ? HALF - lat_s - 1 : 1);
      end else if (i == 10 && strobe != 0) begin
        cyc(lat_s);
        if (strobe == 1) rd_en = 1'b1; else clr_err = 1'b1;
        cyc(1);
        rd_en = 1'b0; clr_err = 1'b0;
        cyc(HALF - lat_s - 1);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1, -1, 0, 11);
    model_frame(b, odd_par(b), 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    cyc(3);
    check_all("reset");
    rst = 1'b0;
    cyc(3);

    send_frame(8'h1C, 1'b0, 1'b1, -1, 3, 11);
    model_frame(8'h1C, 1'b0, 1'b1);
    check_all("good_1C");
    do_read();
    check_all("read_empty");

    send_frame(8'h1C, 1'b1, 1'b1, -1, 0, 11);
    model_frame(8'h1C, 1'b1, 1'b1);
    check_all("bad_parity");
    good_frame(8'hF0);
    check_all("after_F0");
    do_clear();
    check_all("clr_err");
    do_read();

    send_frame(8'h1C, 1'b0, 1'b1, -1, 0, 5);
    cyc(TMO + 50);
    m_fe = 1'b1;
    check_all("timeout");
    good_frame(8'h1C);
    check_all("after_timeout");
    do_read();
    do_clear();

    for (int i = 1; i <= 9; i++) good_frame(8'(i));
    check_all("overflow");
    for (int i = 0; i < 8; i++) begin
      do_read();
      check_all("drain");
    end
    do_clear();

    for (int i = 0; i < DEPTH; i++) good_frame(8'($urandom));
    check_all("full");
    send_frame(8'h0A, odd_par(8'h0A), 1'b1, -1, 1, 11);
    void'(q.pop_front());
    model_frame(8'h0A, odd_par(8'h0A), 1'b1);
    check_all("push_pop_full");
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pp", data, q[0]);
      do_read();
    end
    chk("last_is_0A_empty", ready, 1'b0);

    send_frame(8'h55, odd_par(8'h55), 1'b0, -1, 0, 11);
    model_frame(8'h55, odd_par(8'h55), 1'b0);
    check_all("stop_bad");
    send_frame(8'h1C, 1'b1, 1'b1, -1, 2, 11);
    m_ovf = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
    model_frame(8'h1C, 1'b1, 1'b1);
    check_all("clr_vs_event");
    do_clear();

    send_frame(8'h1C, 1'b0, 1'b1, 4, 0, 11);
    model_frame(8'h1C, 1'b0, 1'b1);
    check_all("glitch");

    send_frame(8'h33, 1'b1, 1'b0, -1, 0, 11);
    model_frame(8'h33, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 0, 4);
    rst = 1'b1;
    cyc(2);
    q.delete(); m_ovf = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
    check_all("mid_reset");
    rst = 1'b0;
    cyc(3);
    good_frame(8'hA7);
    check_all("after_reset");

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        send_frame(b, odd_par(b), 1'b0, -1, 0, 11);
        model_frame(b, odd_par(b), 1'b0);
      end else if (kind == 1) begin
        send_frame(b, ~odd_par(b), 1'b1, -1, 0, 11);
        model_frame(b, ~odd_par(b), 1'b1);
      end else begin
        good_frame(b);
      end
      check_all("rand_frame");
      repeat ($urandom_range(0, 2)) do_read();
      if ($urandom_range(0, 3) == 0) do_clear();
      check_all("rand_post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
